pc_fetch_stage: RTL and testbench

- Program-counter and IF/ID pipeline register for the processor's fetch stage.
- Directly consumes the 15-bit branch offset produced by shift_left_by_1.
- Adds that offset to the branch instruction's return PC to redirect fetch.
- Drives the instruction-memory address, captures returned instructions and presents them to decode with a valid flag, handling stall, memory wait and branch flush.

---
 rtl/pc_fetch_stage.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter and IF/ID pipeline register for the fetch
// stage. Redirects on taken branches using the pre-shifted 15-bit offset
// (target = branch_pc + PC_STEP + branch_offset, silently wrapping), issues
// instruction-memory requests, waits on imem_ready, and honours decode stall.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / bubble_count outputs.
module pc_fetch_stage #(
  parameter int PC_WIDTH    = 15,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 2,
  parameter int RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            bubble_count
`endif
);

  localparam logic [PC_WIDTH-1:0] LP_STEP     = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] LP_RESET_PC = PC_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_imem_req;
  logic                   r_if_valid;
  logic [INSTR_WIDTH-1:0] r_if_instr;
  logic [PC_WIDTH-1:0]    r_if_pc_next;

  logic [PC_WIDTH-1:0]    w_target;
  logic [PC_WIDTH-1:0]    w_pc_inc;

  // Branch target and sequential PC; both wrap modulo 2^PC_WIDTH by width.
  assign w_target = branch_pc + LP_STEP + branch_offset;
  assign w_pc_inc = r_pc + LP_STEP;

  assign imem_addr  = r_pc;
  assign imem_req   = r_imem_req;
  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_pc_next = r_if_pc_next;

  // Fetch FSM: PC, request flag and IF/ID register, priority branch > stall > ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= LP_RESET_PC;
      r_imem_req   <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc_next <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // One settling cycle after reset; all inputs ignored here.
          r_state    <= ST_RUN;
          r_imem_req <= 1'b1;
        end
        ST_RUN, ST_WAIT: begin
          r_imem_req <= 1'b1;
          if (branch_taken) begin
            // Redirect and flush; any outstanding request is abandoned.
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
            r_state    <= ST_RUN;
          end else if (stall) begin
            // Decode busy: hold everything, including the current state.
            r_state <= r_state;
          end else if (imem_ready) begin
            r_if_instr   <= imem_rdata;
            r_if_pc_next <= w_pc_inc;
            r_if_valid   <= 1'b1;
            r_pc         <= w_pc_inc;
            r_state      <= ST_RUN;
          end else begin
            r_if_valid <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        default: begin
          // Unreachable encoding: recover through IDLE with a flushed IF/ID.
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        w_active;
  logic        w_capture;
  logic        w_valid_nxt;
  logic        w_bubble;
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  // Capture and next-valid decode mirroring the FSM priorities.
  assign w_active    = (r_state == ST_RUN) || (r_state == ST_WAIT);
  assign w_capture   = w_active && !branch_taken && !stall && imem_ready;
  assign w_valid_nxt = branch_taken ? 1'b0 :
                       stall        ? r_if_valid :
                       imem_ready;
  assign w_bubble    = w_active && !w_valid_nxt;

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;

  // Performance counters: captures and empty IF/ID cycles, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_capture) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_fetch_count <= r_fetch_count;
      end
      if (w_bubble) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end else begin
        r_bubble_count <= r_bubble_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed test-plan steps followed
// by randomized cycles, all compared against a cycle-level reference model.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [14:0] branch_pc;
  logic [14:0] branch_offset;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [14:0] if_pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  pc_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc_next    (if_pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: PC as a plain integer modulo 32768. Outside the
  // post-reset settling cycle, "running" and "waiting" behave alike, so the
  // model only tracks whether it is still settling.
  int          m_pc      = 0;
  bit          m_settle  = 1'b1;
  bit          m_req     = 1'b0;
  bit          m_valid   = 1'b0;
  logic [31:0] m_instr   = 32'h0;
  int          m_pcn     = 0;
  longint      m_fetches = 0;
  longint      m_bubbles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit b, input int bpc, input int boff,
                            input bit st, input bit rdy, input logic [31:0] rd);
    if (!r) begin
      m_pc = 0; m_settle = 1'b1; m_req = 1'b0; m_valid = 1'b0;
      m_instr = 32'h0; m_pcn = 0; m_fetches = 0; m_bubbles = 0;
    end else if (m_settle) begin
      m_settle = 1'b0;
      m_req    = 1'b1;
    end else begin
      if (b) begin
        m_pc    = (bpc + 2 + boff) % 32768;
        m_valid = 1'b0;
      end else if (st) begin
        m_pc = m_pc;
      end else if (rdy) begin
        m_instr = rd;
        m_pcn   = (m_pc + 2) % 32768;
        m_pc    = m_pcn;
        m_valid = 1'b1;
        m_fetches++;
      end else begin
        m_valid = 1'b0;
      end
      if (!m_valid) m_bubbles++;
    end
  endtask

  task automatic compare_all();
    chk("imem_req",   32'(imem_req),   32'(m_req));
    chk("imem_addr",  32'(imem_addr),  32'(m_pc));
    chk("if_valid",   32'(if_valid),   32'(m_valid));
    chk("if_instr",   if_instr,        m_instr);
    chk("if_pc_next", 32'(if_pc_next), 32'(m_pcn));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count",  fetch_count,  32'(m_fetches));
    chk("bubble_count", bubble_count, 32'(m_bubbles));
`endif
  endtask

  // Drive inputs, clock one edge, update model, sample 1 time unit later.
  task automatic step(input bit r, input bit b, input logic [14:0] bpc, input logic [14:0] boff,
                      input bit st, input bit rdy, input logic [31:0] rd);
    rst_n = r; branch_taken = b; branch_pc = bpc; branch_offset = boff;
    stall = st; imem_ready = rdy; imem_rdata = rd;
    @(posedge clk);
    model_edge(r, b, int'(bpc), int'(boff), st, rdy, rd);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_pc = 15'h0;
    branch_offset = 15'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    #2;

    // Reset, then the settling cycle with imem_ready already high.
    step(1'b0, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'hAAAA0001);
    chk("reset_addr", 32'(imem_addr), 32'h0);
    chk("reset_req",  32'(imem_req),  32'h0);
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'hAAAA0001);
    chk("idle_no_capture", 32'(if_valid), 32'h0);
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'hAAAA0001);
    chk("first_instr", if_instr, 32'hAAAA0001);
    chk("first_pcn",   32'(if_pc_next), 32'h2);
    chk("first_addr",  32'(imem_addr),  32'h2);

    // Forward branch, then the next capture.
    step(1'b1, 1'b1, 15'h0010, 15'h0440, 1'b0, 1'b1, 32'h0);
    chk("fwd_target", 32'(imem_addr), 32'h0452);
    chk("fwd_flush",  32'(if_valid),  32'h0);
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'hCAFE0002);
    chk("fwd_pcn", 32'(if_pc_next), 32'h0454);

    // Backward branch and target wrap.
    step(1'b1, 1'b1, 15'h0008, 15'h7FFC, 1'b0, 1'b0, 32'h0);
    chk("bwd_target", 32'(imem_addr), 32'h0006);
    step(1'b1, 1'b1, 15'h7FFE, 15'h0004, 1'b0, 1'b0, 32'h0);
    chk("wrap_target", 32'(imem_addr), 32'h0004);

    // Memory wait at 0x0020 for three cycles.
    step(1'b1, 1'b1, 15'h0000, 15'h001E, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 32'h0);
      chk("wait_addr",  32'(imem_addr), 32'h0020);
      chk("wait_valid", 32'(if_valid),  32'h0);
    end
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'h12345678);
    chk("wait_instr", if_instr, 32'h12345678);
    chk("wait_pc",    32'(imem_addr), 32'h0022);

    // Stall with a valid IF/ID for two cycles.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 15'h0, 15'h0, 1'b1, 1'b1, 32'hDEADBEEF);
      chk("stall_instr", if_instr, 32'h12345678);
      chk("stall_valid", 32'(if_valid), 32'h1);
      chk("stall_pc",    32'(imem_addr), 32'h0022);
    end

    // Branch beats stall.
    step(1'b1, 1'b1, 15'h0100, 15'h0000, 1'b1, 1'b1, 32'h0);
    chk("br_over_stall_pc",    32'(imem_addr), 32'h0102);
    chk("br_over_stall_valid", 32'(if_valid),  32'h0);

    // Enter WAIT, then stall with ready high: no capture.
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b1, 1'b1, 32'h55555555);
    chk("wait_stall_valid", 32'(if_valid),  32'h0);
    chk("wait_stall_pc",    32'(imem_addr), 32'h0102);

    // Reset during WAIT with a branch pending.
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 15'h0200, 15'h0010, 1'b0, 1'b1, 32'h0);
    chk("rst_wait_pc",    32'(imem_addr), 32'h0);
    chk("rst_wait_valid", 32'(if_valid),  32'h0);
    chk("rst_wait_req",   32'(imem_req),  32'h0);

    // Sequential wrap from 0x7FFE to 0.
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 15'h7FFA, 15'h0002, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 15'h0, 15'h0, 1'b0, 1'b1, 32'h0BADF00D);
    chk("seq_wrap_pc",  32'(imem_addr),  32'h0);
    chk("seq_wrap_pcn", 32'(if_pc_next), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 7) == 0),
           15'($urandom), 15'($urandom),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
